// File: rtl/cla16_wide_add_seq_if.sv
// Request/result handshake and shared CLA16 adder bus for cla16_wide_add_seq.
// The op port exists only when CLA16_SEQ_SUB_EN is defined.
interface cla16_wide_add_seq_if #(
  parameter int WORDS = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [16*WORDS-1:0]    a;
  logic [16*WORDS-1:0]    b;
  logic                   cin;
`ifdef CLA16_SEQ_SUB_EN
  logic                   op;
`endif
  logic                   out_valid;
  logic                   out_ready;
  logic [16*WORDS-1:0]    sum;
  logic                   cout;
  logic                   busy;
  logic [15:0]            add_x;
  logic [15:0]            add_y;
  logic                   add_cin;
  logic [15:0]            add_sum;
  logic                   add_cout;

  modport slave (
    input  in_valid, a, b, cin,
`ifdef CLA16_SEQ_SUB_EN
    input  op,
`endif
    input  out_ready, add_sum, add_cout,
    output in_ready, out_valid, sum, cout, busy, add_x, add_y, add_cin
  );

  modport master (
    output in_valid, a, b, cin,
`ifdef CLA16_SEQ_SUB_EN
    output op,
`endif
    output out_ready, add_sum, add_cout,
    input  in_ready, out_valid, sum, cout, busy, add_x, add_y, add_cin
  );
endinterface

// File: rtl/cla16_wide_add_seq.sv
// Time-multiplexes one external CLA16 over WORDS cycles to build a 16*WORDS-bit sum.
// Define CLA16_SEQ_SUB_EN to add the op input (op=1 computes a-b).
module cla16_wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla16_wide_add_seq_if.slave   bus
);
  localparam int W    = 16 * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [IDXW-1:0]   idx_reg, idx_next;
  logic              carry_reg, carry_next;
  logic [W-1:0]      a_reg, a_next;
  logic [W-1:0]      b_reg, b_next;
  logic [W-1:0]      sum_reg, sum_next;
  logic              cout_reg, cout_next;
  logic              op_eff;

`ifdef CLA16_SEQ_SUB_EN
  logic              op_reg, op_next;
  assign op_eff = op_reg;
`else
  assign op_eff = 1'b0;
`endif

  logic [15:0]       a_slice [WORDS];
  logic [15:0]       b_slice [WORDS];
  logic [W-1:0]      sum_upd;

  // Only the slice addressed by idx takes the adder result; the rest hold.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_slice
      assign a_slice[gi] = a_reg[16*gi +: 16];
      assign b_slice[gi] = b_reg[16*gi +: 16];
      assign sum_upd[16*gi +: 16] = (idx_reg == IDXW'(gi)) ? bus.add_sum
                                                           : sum_reg[16*gi +: 16];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
`ifdef CLA16_SEQ_SUB_EN
      op_reg    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      carry_reg <= carry_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
`ifdef CLA16_SEQ_SUB_EN
      op_reg    <= op_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    carry_next = carry_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
`ifdef CLA16_SEQ_SUB_EN
    op_next    = op_reg;
`endif

    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.add_x     = 16'h0000;
    bus.add_y     = 16'h0000;
    bus.add_cin   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_next     = bus.a;
          b_next     = bus.b;
          idx_next   = '0;
          carry_next = bus.cin;
`ifdef CLA16_SEQ_SUB_EN
          op_next    = bus.op;
          // Subtraction is a + ~b + 1, so the initial carry is forced high.
          if (bus.op) carry_next = 1'b1;
`endif
          state_next = RUN;
        end
      end
      RUN: begin
        bus.busy    = 1'b1;
        bus.add_x   = a_slice[idx_reg];
        bus.add_y   = op_eff ? ~b_slice[idx_reg] : b_slice[idx_reg];
        bus.add_cin = carry_reg;
        sum_next    = sum_upd;
        carry_next  = bus.add_cout;
        idx_next    = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          cout_next  = bus.add_cout;
          state_next = DONE;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
endmodule

// File: tb/tb_cla16_wide_add_seq.sv
// Bench for cla16_wide_add_seq: behavioural CLA16, arithmetic reference model
// checked every cycle, plus directed cases with literal expectations.
module tb_cla16_wide_add_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;
  localparam int TMO   = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla16_wide_add_seq_if #(.WORDS(WORDS)) bus ();

  cla16_wide_add_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural stand-in for the external CLA16.
  logic [16:0] add_full;
  assign add_full     = {1'b0, bus.add_x} + {1'b0, bus.add_y} + 17'(bus.add_cin);
  assign bus.add_sum  = add_full[15:0];
  assign bus.add_cout = add_full[16];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] y;   // effective second operand (b or ~b)
    logic         c0;  // effective carry into slice 0
    int           acc; // index of the accept edge
  } req_t;

  req_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [W:0] act, logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no response within %0d cycles (cycle %0d)", name, TMO, cyc);
  endtask

  function automatic logic [W:0] full_sum(req_t r);
    return {1'b0, r.a} + {1'b0, r.y} + (W+1)'(r.c0);
  endfunction

  // Carry entering slice k = carry out of the low 16*k bits of the true sum.
  function automatic logic carry_into(req_t r, int k);
    logic [W:0] m;
    logic [W:0] s;
    m = ((W+1)'(1) << (16 * k)) - (W+1)'(1);
    s = ({1'b0, r.a} & m) + ({1'b0, r.y} & m) + (W+1)'(r.c0);
    return s[16 * k];
  endfunction

  // Compare process: state is "nothing in flight" or "front request, k cycles since accept".
  always @(negedge clk) begin : mon
    int   k;
    bit   was_empty;
    req_t r;
    logic [W:0] f;
    logic [W-1:0] bv;
    if (mon_en) begin
      was_empty = (q.size() == 0);
      k = 0;
      if (was_empty) begin
        check("idle_in_ready", (W+1)'(bus.in_ready), (W+1)'(1));
        check("idle_busy",     (W+1)'(bus.busy), (W+1)'(0));
        check("idle_out_valid",(W+1)'(bus.out_valid), (W+1)'(0));
        check("idle_add_x",    (W+1)'(bus.add_x), (W+1)'(0));
        check("idle_add_y",    (W+1)'(bus.add_y), (W+1)'(0));
        check("idle_add_cin",  (W+1)'(bus.add_cin), (W+1)'(0));
      end else begin
        r = q[0];
        k = cyc - r.acc;
        check("busy_in_ready", (W+1)'(bus.in_ready), (W+1)'(0));
        check("busy_busy",     (W+1)'(bus.busy), (W+1)'(1));
        if (k < WORDS) begin
          check("run_out_valid", (W+1)'(bus.out_valid), (W+1)'(0));
          check("run_add_x",   (W+1)'(bus.add_x), (W+1)'(r.a[16*k +: 16]));
          check("run_add_y",   (W+1)'(bus.add_y), (W+1)'(r.y[16*k +: 16]));
          check("run_add_cin", (W+1)'(bus.add_cin), (W+1)'(carry_into(r, k)));
        end else begin
          f = full_sum(r);
          check("done_out_valid", (W+1)'(bus.out_valid), (W+1)'(1));
          check("done_result", {bus.cout, bus.sum}, f);
          check("done_add_x", (W+1)'(bus.add_x), (W+1)'(0));
        end
      end
      if (!rst_n) begin
        q.delete();
      end else begin
        if (!was_empty && k >= WORDS && bus.out_ready) void'(q.pop_front());
        if (was_empty && bus.in_valid) begin
          r.a  = bus.a;
          bv   = bus.b;
          r.y  = bv;
          r.c0 = bus.cin;
`ifdef CLA16_SEQ_SUB_EN
          if (bus.op) begin
            r.y  = ~bv;
            r.c0 = 1'b1;
          end
`endif
          r.acc = cyc + 1;
          q.push_back(r);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return one step after the accepting edge.
  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic c, logic op, bit keep);
    bus.a = a;
    bus.b = b;
    bus.cin = c;
`ifdef CLA16_SEQ_SUB_EN
    bus.op = op;
`else
    if (op) bus.cin = c;
`endif
    bus.in_valid = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      if (bus.in_ready) begin
        tick();
        if (!keep) bus.in_valid = 1'b0;
        return;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    timeout("send_accept");
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    timeout("wait_out_valid");
  endtask

  task automatic collect(int stall, bit lit, logic [W-1:0] es, logic ec);
    bit ok;
    wait_valid(ok);
    if (!ok) return;
    if (lit) begin
      check("lit_sum",  (W+1)'(bus.sum), (W+1)'(es));
      check("lit_cout", (W+1)'(bus.cout), (W+1)'(ec));
    end
    for (int i = 0; i < stall; i++) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    logic [W-1:0] held_sum;
    logic         held_cout;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
`ifdef CLA16_SEQ_SUB_EN
    bus.op        = 1'b0;
`endif
    repeat (3) tick();
    check("rst_in_ready",  (W+1)'(bus.in_ready), (W+1)'(1));
    check("rst_out_valid", (W+1)'(bus.out_valid), (W+1)'(0));
    check("rst_busy",      (W+1)'(bus.busy), (W+1)'(0));
    check("rst_sum",       (W+1)'(bus.sum), (W+1)'(0));
    check("rst_cout",      (W+1)'(bus.cout), (W+1)'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Carry out of slice 0 into slice 1.
    send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
    tick();
    check("slice1_add_cin", (W+1)'(bus.add_cin), (W+1)'(1));
    collect(0, 1'b1, 64'h0000_0000_0001_0000, 1'b0);

    // Full ripple through every slice.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b0);
    collect(0, 1'b1, 64'h0, 1'b1);

    // Result backpressure with a stray request pulse.
    send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0);
    wait_valid(ok);
    if (ok) begin
      held_sum  = bus.sum;
      held_cout = bus.cout;
      check("bp_sum", (W+1)'(held_sum), (W+1)'(64'h2345_6789_ABCD_F001));
      for (int i = 0; i < 3; i++) begin
        bus.a = 64'hDEAD_BEEF_0000_0001;
        bus.in_valid = (i == 1);
        tick();
        check("bp_sum_stable",  (W+1)'(bus.sum), (W+1)'(held_sum));
        check("bp_cout_stable", (W+1)'(bus.cout), (W+1)'(held_cout));
        check("bp_in_ready",    (W+1)'(bus.in_ready), (W+1)'(0));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("bp_release_in_ready", (W+1)'(bus.in_ready), (W+1)'(1));
    end

    // Reset while idx==2 throws the operation away.
    send(64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_in_ready",  (W+1)'(bus.in_ready), (W+1)'(1));
    check("mid_rst_out_valid", (W+1)'(bus.out_valid), (W+1)'(0));
    check("mid_rst_busy",      (W+1)'(bus.busy), (W+1)'(0));
    check("mid_rst_add_x",     (W+1)'(bus.add_x), (W+1)'(0));
    check("mid_rst_add_y",     (W+1)'(bus.add_y), (W+1)'(0));
    check("mid_rst_sum",       (W+1)'(bus.sum), (W+1)'(0));
    repeat (8) tick();

`ifdef CLA16_SEQ_SUB_EN
    send(64'h5, 64'h7, 1'b0, 1'b1, 1'b0);
    collect(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    send(64'h7, 64'h5, 1'b0, 1'b1, 1'b0);
    collect(1, 1'b1, 64'h2, 1'b1);
    send(64'h7, 64'h5, 1'b1, 1'b0, 1'b0);
    collect(0, 1'b1, 64'hD, 1'b0);
`endif

    // Back-to-back with in_valid held: second accept right after the handshake.
    bus.out_ready = 1'b1;
    send(64'h3, 64'h4, 1'b0, 1'b0, 1'b1);
    bus.a = 64'h8000_0000_0000_0000;
    bus.b = 64'h8000_0000_0000_0000;
    wait_valid(ok);
    if (ok) begin
      check("b2b_first_sum", (W+1)'(bus.sum), (W+1)'(64'h7));
      tick();
      check("b2b_idle_in_ready", (W+1)'(bus.in_ready), (W+1)'(1));
      tick();
      bus.in_valid = 1'b0;
      check("b2b_second_busy", (W+1)'(bus.busy), (W+1)'(1));
      collect(0, 1'b1, 64'h0, 1'b1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (n % 7 == 0) ra = '1;
      if (n % 11 == 0) rb = {$urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0, 32'hFFFF_FFFF};
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      collect(int'($urandom_range(0, 2)), 1'b0, '0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cla16_wide_add_seq.md
Name: cla16_wide_add_seq

Overview:
- Sequences one shared external CLA16 16-bit adder over WORDS cycles to form a (16*WORDS)-bit sum.
- Carry is chained through a register between cycles, LSB slice first.
- Sits between a wide-operand requester (multiplier partial-product accumulation) and a single CLA16 instance.
- Valid/ready handshake on input and output.

Parameters:
- WORDS, 4, number of 16-bit slices. Operand width is 16*WORDS. Legal range is 1..16.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- a  in  16*WORDS  operand A
- b  in  16*WORDS  operand B
- cin  in  1  carry into slice 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  16*WORDS  result
- cout  out  1  carry out of top slice
- busy  out  1  high in RUN or DONE
- add_x  out  16  to CLA16 X
- add_y  out  16  to CLA16 Y
- add_cin  out  1  to CLA16 carry_in
- add_sum  in  16  from CLA16 sum, combinational
- add_cout  in  1  from CLA16 carry_out

Behaviour:
- Reset: clk and rst_n form one clock domain. Reset is synchronous and active-low. While rst_n=0 at a clk edge, the block enters IDLE. After that edge: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, and the slice index, carry register and operand registers are 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register a, b and cin. Set carry_r=cin and idx=0, then go to RUN.
- RUN:
  - add_x=a_r[16*idx+:16], add_y=b_r[16*idx+:16], add_cin=carry_r, all combinational from registers.
  - Each edge: sum[16*idx+:16] <= add_sum, carry_r <= add_cout, idx <= idx+1.
  - At the edge where idx==WORDS-1: cout <= add_cout, go to DONE.
  - in_ready=0. Inputs are ignored.
- DONE:
  - out_valid=1. sum and cout are held stable.
  - On out_ready=1 at an edge, go to IDLE. There is no same-cycle accept of a new request in DONE, so in_ready stays 0.
- Adder drive outside RUN: add_x=0, add_y=0, add_cin=0.
- Latency:
  - Accept at edge T.
  - Slices are captured at edges T+1..T+WORDS.
  - out_valid rises after edge T+WORDS.
  - Minimum request-to-request interval is WORDS+2 cycles.
- WORDS=1: RUN lasts one cycle.
- Arithmetic is modulo 2^(16*WORDS). cout is the true carry out. No overflow flag.
- sum slices not yet written during RUN keep their previous values. They are only valid when out_valid=1.
- Reset mid-RUN or mid-DONE: the operation is discarded, all outputs return to reset values, and no out_valid is produced for it.
- in_valid held high across DONE->IDLE: the request is accepted in IDLE on the cycle after the out handshake.

Optional Feature:
- Macro: CLA16_SEQ_SUB_EN.
- Defined:
  - Adds input port op (1 bit), registered with the operands.
  - op=1 performs a-b: add_y=~b_r slice, initial carry_r=1, cin ignored. cout=1 means no borrow.
  - op=0 is identical to the add path.
- Undefined: no op port. Add only.

Test Plan (WORDS=4):
- a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> sum=0x0000_0000_0001_0000, cout=0. out_valid high exactly 4 cycles after the accept edge. add_cin=1 during slice 1.
- a=0xFFFF_FFFF_FFFF_FFFF, b=0x0, cin=1 -> sum=0, cout=1. The carry ripples through all 4 slices.
- Backpressure on result 0x1234_5678_9ABC_DEF0+0x1111_1111_1111_1111 = 0x2345_6789_ABCD_F001: hold out_ready=0 for 3 cycles -> sum and cout stable, in_ready=0, and a pulsed in_valid is not accepted. Then out_ready=1 -> IDLE next cycle.
- Drive rst_n=0 for one edge while idx=2 in RUN -> next cycle in_ready=1, out_valid=0, busy=0, add_x=add_y=0. No result appears afterwards.
- With CLA16_SEQ_SUB_EN: a=5, b=7, op=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. Then a=7, b=5, op=1 -> sum=2, cout=1.
- Back-to-back: in_valid held high with two requests, out_ready=1 -> second accept occurs one cycle after the first out handshake. Results are 3+4=7, then 0x8000_0000_0000_0000 ×2 -> sum=0, cout=1.
